// File: rtl/ram_boot_loader.sv
// Boot sequencer: frames A5 + 32-bit word count + little-endian words from a byte stream into
// consecutive instruction RAM writes, holding the CPU in reset (rst_boot) while loading.
module ram_boot_loader #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned WAIT_CYCLES  = 1000000,
    parameter int unsigned BYTE_TIMEOUT = 100000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        boot_req,
    output logic        boot_we,
    output logic [3:0]  boot_be,
    output logic [31:0] boot_addr,
    output logic [31:0] boot_wdata,
    input  logic        boot_gnt,
    output logic        rst_boot,
    output logic        boot_done,
    output logic        boot_err
);

    localparam logic [31:0] WAIT_LAST    = 32'(WAIT_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(BYTE_TIMEOUT - 1);
    localparam logic [31:0] DEPTH_MAX    = 32'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_WAIT, S_RUN, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t      state, state_next;
    logic [31:0] wait_cnt, wait_cnt_next;
    logic [31:0] gap_cnt, gap_cnt_next;
    logic [1:0]  byte_idx, byte_idx_next;
    logic [31:0] len, len_next;
    logic [31:0] count, count_next;
    logic [31:0] addr_next, wdata_next;
    logic        req_next, done_next, err_next, rst_boot_next;
    logic        accept, sync_hit;
    logic [31:0] len_full;

    assign rx_ready = (state == S_WAIT) || (state == S_RUN) ||
                      (state == S_LEN)  || (state == S_DATA);
    assign accept   = rx_valid && rx_ready;
    assign sync_hit = accept && (rx_data == SYNC_BYTE) &&
                      ((state == S_WAIT) || (state == S_RUN));
    assign len_full = {rx_data, len[23:0]};

    assign boot_we  = boot_req;
    assign boot_be  = boot_req ? 4'hF : 4'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_WAIT;
            wait_cnt   <= '0;
            gap_cnt    <= '0;
            byte_idx   <= '0;
            len        <= '0;
            count      <= '0;
            boot_addr  <= BASE_ADDR;
            boot_wdata <= '0;
            boot_req   <= 1'b0;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
            rst_boot   <= 1'b1;
        end else begin
            state      <= state_next;
            wait_cnt   <= wait_cnt_next;
            gap_cnt    <= gap_cnt_next;
            byte_idx   <= byte_idx_next;
            len        <= len_next;
            count      <= count_next;
            boot_addr  <= addr_next;
            boot_wdata <= wdata_next;
            boot_req   <= req_next;
            boot_done  <= done_next;
            boot_err   <= err_next;
            rst_boot   <= rst_boot_next;
        end
    end

    always_comb begin
        state_next     = state;
        wait_cnt_next  = wait_cnt;
        gap_cnt_next   = gap_cnt;
        byte_idx_next  = byte_idx;
        len_next       = len;
        count_next     = count;
        addr_next      = boot_addr;
        wdata_next     = boot_wdata;
        req_next       = boot_req;
        done_next      = 1'b0;
        err_next       = boot_err;
        rst_boot_next  = rst_boot;

        case (state)
            S_WAIT: begin
                wait_cnt_next = wait_cnt + 32'd1;
                if (!sync_hit && (wait_cnt == WAIT_LAST)) begin
                    state_next    = S_RUN;
                    rst_boot_next = 1'b0;
                end
            end
            S_RUN: begin
                rst_boot_next = 1'b0;
            end
            S_LEN: begin
                if (accept) begin
                    gap_cnt_next = '0;
                    len_next[{byte_idx, 3'b000} +: 8] = rx_data;
                    byte_idx_next = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        if (len_full == 32'd0) begin
                            state_next = S_DONE;
                            done_next  = 1'b1;
                        end else if (len_full > DEPTH_MAX) begin
                            state_next = S_ERR;
                            err_next   = 1'b1;
                        end else begin
                            state_next = S_DATA;
                        end
                    end
                end else begin
                    gap_cnt_next = gap_cnt + 32'd1;
                    if (gap_cnt == TIMEOUT_LAST) begin
                        state_next = S_ERR;
                        err_next   = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    gap_cnt_next = '0;
                    wdata_next[{byte_idx, 3'b000} +: 8] = rx_data;
                    byte_idx_next = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state_next = S_WRITE;
                        req_next   = 1'b1;
                    end
                end else begin
                    gap_cnt_next = gap_cnt + 32'd1;
                    if (gap_cnt == TIMEOUT_LAST) begin
                        state_next = S_ERR;
                        err_next   = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // A grant stall is legal here, so the byte gap counter is frozen.
                if (boot_gnt) begin
                    req_next     = 1'b0;
                    count_next   = count + 32'd1;
                    addr_next    = boot_addr + 32'd4;
                    gap_cnt_next = '0;
                    if ((count + 32'd1) == len) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DONE: begin
                state_next    = S_RUN;
                rst_boot_next = 1'b0;
            end
            S_ERR: begin
                state_next    = S_WAIT;
                wait_cnt_next = '0;
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase

        // A new frame restarts from a clean slate and re-takes the RAM port.
        if (sync_hit) begin
            state_next    = S_LEN;
            err_next      = 1'b0;
            byte_idx_next = '0;
            count_next    = '0;
            len_next      = '0;
            gap_cnt_next  = '0;
            addr_next     = BASE_ADDR;
            rst_boot_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_boot_loader.sv
// Directed bench for ram_boot_loader: expected RAM writes go into a scoreboard queue, a monitor
// pops and compares them on every granted request; timing of rst_boot/boot_done/boot_err is checked inline.
module tb_ram_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        boot_req;
    logic        boot_we;
    logic [3:0]  boot_be;
    logic [31:0] boot_addr;
    logic [31:0] boot_wdata;
    logic        boot_gnt;
    logic        rst_boot;
    logic        boot_done;
    logic        boot_err;

    int n_cmp = 0;
    int n_fail = 0;
    int n_writes = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    ram_boot_loader #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (100),
        .BYTE_TIMEOUT(50),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .boot_req  (boot_req),
        .boot_we   (boot_we),
        .boot_be   (boot_be),
        .boot_addr (boot_addr),
        .boot_wdata(boot_wdata),
        .boot_gnt  (boot_gnt),
        .rst_boot  (rst_boot),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!rx_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rx_ready_timeout: byte %h not accepted, expected acceptance", b);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && boot_req && boot_gnt) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write", boot_addr, boot_wdata);
            end else begin
                exp_e = exp_q.pop_front();
                check32("wr_addr", boot_addr, exp_e[63:32]);
                check32("wr_data", boot_wdata, exp_e[31:0]);
                check32("wr_be", {28'b0, boot_be}, 32'hF);
                check_bit("wr_we", boot_we, 1'b1);
            end
            n_writes++;
        end
        if (boot_done) done_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [31:0] w;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        boot_gnt = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check_bit("rst_rst_boot", rst_boot, 1'b1);
        check_bit("rst_rx_ready", rx_ready, 1'b1);
        check_bit("rst_boot_req", boot_req, 1'b0);
        check32("rst_boot_be", {28'b0, boot_be}, 32'h0);
        check32("rst_boot_addr", boot_addr, BASE);
        check32("rst_boot_wdata", boot_wdata, 32'h0);
        check_bit("rst_boot_done", boot_done, 1'b0);
        check_bit("rst_boot_err", boot_err, 1'b0);

        // T1: no bytes, CPU released exactly 100 cycles after reset release
        #1 rst = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (i == 99)  check_bit("t1_rst_boot_cyc99", rst_boot, 1'b1);
            if (i == 100) check_bit("t1_rst_boot_cyc100", rst_boot, 1'b0);
        end
        check32("t1_no_writes", 32'(n_writes), 32'd0);

        // T2: two-word frame, grant always high
        send_byte(8'hA5);
        check_bit("t2_rst_boot_after_sync", rst_boot, 1'b1);
        expect_write(BASE, 32'h1234_5678);
        expect_write(BASE + 32'd4, 32'hDEAD_BEEF);
        send_word(32'd2);
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        @(negedge clk);
        check_bit("t2_req_last", boot_req, 1'b1);
        check_bit("t2_done_early", boot_done, 1'b0);
        @(negedge clk);
        check_bit("t2_done_pulse", boot_done, 1'b1);
        check_bit("t2_rst_boot_in_done", rst_boot, 1'b1);
        @(negedge clk);
        check_bit("t2_done_cleared", boot_done, 1'b0);
        check_bit("t2_rst_boot_released", rst_boot, 1'b0);
        check_bit("t2_run_rx_ready", rx_ready, 1'b1);
        check32("t2_writes", 32'(n_writes), 32'd2);
        check32("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        check32("t2_done_cnt", 32'(done_cnt), 32'd1);

        // T3: grant stalled 5 cycles on the first word; sync value inside data is data
        #1 boot_gnt = 1'b0;
        send_byte(8'hA5);
        expect_write(BASE, 32'hA5A5_0001);
        expect_write(BASE + 32'd4, 32'h0BAD_F00D);
        send_word(32'd2);
        send_word(32'hA5A5_0001);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_bit("t3_req_held", boot_req, 1'b1);
            check32("t3_addr_held", boot_addr, BASE);
            check32("t3_wdata_held", boot_wdata, 32'hA5A5_0001);
            check_bit("t3_rx_ready_low", rx_ready, 1'b0);
        end
        check32("t3_be_held", {28'b0, boot_be}, 32'hF);
        check32("t3_no_write_during_stall", 32'(n_writes), 32'd2);
        @(posedge clk);
        #1 boot_gnt = 1'b1;
        send_word(32'h0BAD_F00D);
        repeat (3) @(negedge clk);
        check32("t3_writes", 32'(n_writes), 32'd4);
        check32("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        check32("t3_done_cnt", 32'(done_cnt), 32'd2);
        check_bit("t3_rst_boot", rst_boot, 1'b0);

        // Zero-length frame completes immediately with no writes
        send_byte(8'hA5);
        send_word(32'd0);
        @(negedge clk);
        check_bit("len0_done_pulse", boot_done, 1'b1);
        @(negedge clk);
        check_bit("len0_done_cleared", boot_done, 1'b0);
        @(negedge clk);
        check_bit("len0_rst_boot", rst_boot, 1'b0);
        check32("len0_done_cnt", 32'(done_cnt), 32'd3);
        check32("len0_writes", 32'(n_writes), 32'd4);

        // T4: len one past capacity -> error, back to WAIT holding the CPU
        send_byte(8'hA5);
        send_word(32'h0000_0401);
        @(negedge clk);
        check_bit("t4_err", boot_err, 1'b1);
        check_bit("t4_err_rx_ready", rx_ready, 1'b0);
        check_bit("t4_rst_boot", rst_boot, 1'b1);
        @(negedge clk);
        check_bit("t4_wait_rx_ready", rx_ready, 1'b1);
        check_bit("t4_err_sticky", boot_err, 1'b1);
        check32("t4_writes", 32'(n_writes), 32'd4);

        // T5: byte timeout inside the data word, then sync clears the error
        send_byte(8'hA5);
        check_bit("t5_sync_clears_err", boot_err, 1'b0);
        send_word(32'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (60) @(negedge clk);
        check_bit("t5_timeout_err", boot_err, 1'b1);
        check_bit("t5_rst_boot", rst_boot, 1'b1);
        check32("t5_writes", 32'(n_writes), 32'd4);
        send_byte(8'hA5);
        check_bit("t5_resync_clears_err", boot_err, 1'b0);
        send_word(32'd0);
        repeat (3) @(negedge clk);
        check32("t5_done_cnt", 32'(done_cnt), 32'd4);
        check_bit("t5_rst_boot_released", rst_boot, 1'b0);

        // Frame of exactly DEPTH_WORDS is accepted
        send_byte(8'hA5);
        send_word(32'd1024);
        for (int i = 0; i < 1024; i++) begin
            w = (32'(i) * 32'h0100_0193) ^ 32'hC3A5_5A3C;
            expect_write(BASE + 32'(4 * i), w);
            send_word(w);
        end
        repeat (3) @(negedge clk);
        check32("depth_writes", 32'(n_writes), 32'd1028);
        check32("depth_queue_empty", 32'(exp_q.size()), 32'd0);
        check32("depth_done_cnt", 32'(done_cnt), 32'd5);
        check_bit("depth_err", boot_err, 1'b0);

        // T6: reload from RUN, then async reset during a stalled write
        send_byte(8'hA5);
        check_bit("t6_rst_boot_after_sync", rst_boot, 1'b1);
        send_word(32'd1);
        #1 boot_gnt = 1'b0;
        send_word(32'h55AA_1234);
        @(negedge clk);
        check_bit("t6_req_before_rst", boot_req, 1'b1);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check_bit("t6_req_dropped", boot_req, 1'b0);
        check32("t6_be_dropped", {28'b0, boot_be}, 32'h0);
        check_bit("t6_rst_boot", rst_boot, 1'b1);
        check_bit("t6_wait_rx_ready", rx_ready, 1'b1);
        check32("t6_addr_reset", boot_addr, BASE);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        boot_gnt = 1'b1;
        repeat (5) @(negedge clk);
        check32("t6_no_done", 32'(done_cnt), 32'(d0));
        check_bit("t6_req_idle", boot_req, 1'b0);
        check32("t6_writes", 32'(n_writes), 32'd1028);
        check_bit("t6_rst_boot_held", rst_boot, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
